decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Decode/operand-fetch stage directly upstream of register_file.
- Accepts 16-bit instructions over a valid/ready handshake and drives the register file read ports.
- Tracks pending destination writes with an 8-entry scoreboard, stalls on read-after-write (RAW) hazards, and presents decoded operands to execute through a registered valid/ready output.

Parameters:
- NREGS, 8, number of architectural registers (register index is 3 bits).
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  16  instruction word
- in_pc  in  16  instruction address
- rf_r_en1  out  1  register file read enable, port 1
- rf_r_en2  out  1  register file read enable, port 2
- rf_reg1  out  16  read index, port 1 (zero-extended 3-bit index)
- rf_reg2  out  16  read index, port 2
- rf_r_data1  in  16  read data, port 1 (valid in the same cycle)
- rf_r_data2  in  16  read data, port 2
- wb_valid  in  1  writeback retires a write this cycle
- wb_rd  in  3  writeback destination
- wb_data  in  16  writeback value
- out_valid  out  1  decoded op valid
- out_ready  in  1  execute accepts
- out_opcode  out  4  opcode
- out_rd  out  3  destination
- out_a  out  16  operand A
- out_b  out  16  operand B
- out_imm  out  16  sign-extended immediate
- out_pc  out  16  PC of the op
- out_wr  out  1  op writes rd
- halted  out  1  halt instruction accepted
- stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Instruction fields:
  - opcode = instr[15:12], rd = [11:9], rs1 = [8:6], rs2 = [5:3], imm6 = [5:0].
- Opcode classes:
  - 0x0-0x7 are R-type: read rs1 and rs2.
  - 0x8-0xE are I-type: read rs1 only; out_b = 0; out_imm = sign-extended imm6.
  - 0xF is halt.
- out_wr = 1 iff opcode is not in {0x7, 0xE, 0xF} and rd != 0.
- Register 0:
  - Reads of r0 return 0 regardless of rf_r_data.
  - r0 is never pending.
- Read ports:
  - rf_reg1 = rs1 and rf_reg2 = rs2 combinationally from in_instr.
  - rf_r_en1 and rf_r_en2 are asserted only when in_valid is high and the port is used by the opcode class.
- Scoreboard (pending[7:0]):
  - Set bit rd when an op with out_wr = 1 is captured into the output register.
  - Clear bit wb_rd on wb_valid.
  - Set and clear of the same bit in the same cycle: set wins.
- Hazard:
  - A used source s is blocked when pending[s] = 1 and it is not bypassed (see BYPASS_EN).
  - in_ready = !halted && !blocked && (!out_valid || out_ready).
- Capture:
  - On in_valid && in_ready, the output register loads the decoded fields at the clock edge; latency is 1 cycle.
  - out_valid is held until out_ready; all out_* fields are stable while out_valid && !out_ready.
- Output clear: if out_ready && out_valid with no capture in that cycle, out_valid is cleared.
- FSM:
  - RUN goes to HALTED when a 0xF instruction is captured. The halt op itself is presented on out with out_wr = 0.
  - HALTED holds until reset; in_ready = 0 and halted = 1.
- stall_cycles increments in every cycle with in_valid && blocked, and saturates at all-ones.
- Reset: out_valid = 0, pending = 0, state = RUN, halted = 0, stall_cycles = 0, all out_* data = 0. Reset mid-stall discards both the held op and the input op.

Optional Feature:
- BYPASS_EN defined:
  - A source s is not blocked when wb_valid && wb_rd == s.
  - Its operand takes wb_data instead of rf_r_data.
- BYPASS_EN undefined:
  - A source with pending[s] = 1 always blocks.
  - Issue occurs the cycle after the writeback, reading the register file contents.
  - The stall is one cycle longer per RAW hazard.

Test Plan:
- Reset, then in_instr = 0x0288 (op 0, rd 1, rs1 2, rs2 1), rf data 0x0102/0x0304, out_ready = 1 -> next cycle out_valid = 1, out_a = 0x0102, out_b = 0x0304, out_rd = 1, out_wr = 1, pending = 0x02.
- An op reading r1 right after an op writing r1, with wb arriving 3 cycles later carrying wb_data = 0x0506:
  - BYPASS_EN defined -> issues in the wb cycle with out_a = 0x0506, stall_cycles = 3.
  - BYPASS_EN undefined -> issues one cycle later, stall_cycles = 4.
- I-type 0x8 with imm6 = 0x3F -> out_imm = 0xFFFF, out_b = 0, rf_r_en2 = 0.
- Source r0 with rf_r_data1 = 0xBEEF -> out_a = 0, never stalls; op with rd = 0 -> out_wr = 0, pending unchanged.
- out_ready held low for 4 cycles with in_valid high -> in_ready = 0, out_* stable; out_ready high -> the next op is captured the following edge.
- Halt 0xF000 accepted -> halted = 1 and in_ready = 0 forever; reset -> halted = 0, out_valid = 0, pending = 0.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: decode / operand-fetch stage feeding execute.
// Drives the register file read ports, tracks pending destination writes in
// a per-register scoreboard, stalls on read-after-write hazards and presents
// decoded operands through a registered valid/ready output.
// Optional feature macro: BYPASS_EN (forward same-cycle writeback data to a
// blocked source instead of waiting one more cycle for the register file).
module decode_stage #(
  parameter int NREGS       = 8,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_instr,
  input  logic [15:0]            in_pc,
  output logic                   rf_r_en1,
  output logic                   rf_r_en2,
  output logic [15:0]            rf_reg1,
  output logic [15:0]            rf_reg2,
  input  logic [15:0]            rf_r_data1,
  input  logic [15:0]            rf_r_data2,
  input  logic                   wb_valid,
  input  logic [2:0]             wb_rd,
  input  logic [15:0]            wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_opcode,
  output logic [2:0]             out_rd,
  output logic [15:0]            out_a,
  output logic [15:0]            out_b,
  output logic [15:0]            out_imm,
  output logic [15:0]            out_pc,
  output logic                   out_wr,
  output logic                   halted,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_e;

  state_e                 state_q, state_d;
  logic                   out_valid_q, out_valid_d;
  logic [3:0]             out_opcode_q, out_opcode_d;
  logic [2:0]             out_rd_q, out_rd_d;
  logic [15:0]            out_a_q, out_a_d;
  logic [15:0]            out_b_q, out_b_d;
  logic [15:0]            out_imm_q, out_imm_d;
  logic [15:0]            out_pc_q, out_pc_d;
  logic                   out_wr_q, out_wr_d;
  logic [NREGS-1:0]       pending_q, pending_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  logic [3:0]  opcode;
  logic [2:0]  rd, rs1, rs2;
  logic [5:0]  imm6;
  logic        is_r, is_i, is_halt, use1, use2, dec_wr;
  logic        byp1, byp2, blk1, blk2, blocked, capture;
  logic [15:0] opnd1, opnd2;

  // Field extraction and opcode classification of the incoming instruction.
  always_comb begin
    opcode  = in_instr[15:12];
    rd      = in_instr[11:9];
    rs1     = in_instr[8:6];
    rs2     = in_instr[5:3];
    imm6    = in_instr[5:0];
    is_halt = (opcode == 4'hF);
    is_r    = !opcode[3];
    is_i    = opcode[3] && !is_halt;
    use1    = is_r || is_i;
    use2    = is_r;
    dec_wr  = !(opcode == 4'h7 || opcode == 4'hE || is_halt) && (rd != 3'd0);
  end

`ifdef BYPASS_EN
  // A source retiring this cycle is forwarded from the writeback bus.
  always_comb begin
    byp1 = wb_valid && (wb_rd == rs1);
    byp2 = wb_valid && (wb_rd == rs2);
  end
`else
  // Without forwarding a pending source waits until the register file holds it.
  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
  end
`endif

  // Read ports, hazard detection, operand selection and input handshake.
  always_comb begin
    rf_reg1  = {13'd0, rs1};
    rf_reg2  = {13'd0, rs2};
    rf_r_en1 = in_valid && use1;
    rf_r_en2 = in_valid && use2;
    blk1     = use1 && (rs1 != 3'd0) && pending_q[rs1] && !byp1;
    blk2     = use2 && (rs2 != 3'd0) && pending_q[rs2] && !byp2;
    blocked  = blk1 || blk2;
    opnd1    = (rs1 == 3'd0) ? '0 : (byp1 ? wb_data : rf_r_data1);
    opnd2    = (rs2 == 3'd0) ? '0 : (byp2 ? wb_data : rf_r_data2);
    in_ready = (state_q == S_RUN) && !blocked && (!out_valid_q || out_ready);
    capture  = in_valid && in_ready;
    halted   = (state_q == S_HALTED);
  end

  // Next-state: output register, scoreboard, run/halt FSM and stall counter.
  always_comb begin
    state_d      = state_q;
    out_valid_d  = out_valid_q;
    out_opcode_d = out_opcode_q;
    out_rd_d     = out_rd_q;
    out_a_d      = out_a_q;
    out_b_d      = out_b_q;
    out_imm_d    = out_imm_q;
    out_pc_d     = out_pc_q;
    out_wr_d     = out_wr_q;
    pending_d    = pending_q;
    stall_d      = stall_q;

    if (capture) begin
      out_valid_d  = 1'b1;
      out_opcode_d = opcode;
      out_rd_d     = rd;
      out_a_d      = use1 ? opnd1 : '0;
      out_b_d      = use2 ? opnd2 : '0;
      out_imm_d    = is_i ? {{10{imm6[5]}}, imm6} : '0;
      out_pc_d     = in_pc;
      out_wr_d     = dec_wr;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear first so a same-cycle set of the same register takes priority.
    if (wb_valid) pending_d[wb_rd] = 1'b0;
    if (capture && dec_wr) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;

    if (state_q == S_RUN && capture && is_halt) state_d = S_HALTED;

    if (in_valid && blocked && stall_q != '1) stall_d = stall_q + STALL_CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_RUN;
      out_valid_q  <= 1'b0;
      out_opcode_q <= '0;
      out_rd_q     <= '0;
      out_a_q      <= '0;
      out_b_q      <= '0;
      out_imm_q    <= '0;
      out_pc_q     <= '0;
      out_wr_q     <= 1'b0;
      pending_q    <= '0;
      stall_q      <= '0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_opcode_q <= out_opcode_d;
      out_rd_q     <= out_rd_d;
      out_a_q      <= out_a_d;
      out_b_q      <= out_b_d;
      out_imm_q    <= out_imm_d;
      out_pc_q     <= out_pc_d;
      out_wr_q     <= out_wr_d;
      pending_q    <= pending_d;
      stall_q      <= stall_d;
    end
  end

  // Registered outputs.
  always_comb begin
    out_valid    = out_valid_q;
    out_opcode   = out_opcode_q;
    out_rd       = out_rd_q;
    out_a        = out_a_q;
    out_b        = out_b_q;
    out_imm      = out_imm_q;
    out_pc       = out_pc_q;
    out_wr       = out_wr_q;
    stall_cycles = stall_q;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios plus random instruction
// streams, checked by a scoreboard against program-order register semantics.
module tb_decode_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, in_ready;
  logic [15:0] in_instr, in_pc;
  logic        rf_r_en1, rf_r_en2;
  logic [15:0] rf_reg1, rf_reg2, rf_r_data1, rf_r_data2;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [3:0]  out_opcode;
  logic [2:0]  out_rd;
  logic [15:0] out_a, out_b, out_imm, out_pc;
  logic        out_wr, halted;
  logic [15:0] stall_cycles;

  decode_stage #(.NREGS(8), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .rf_r_en1(rf_r_en1), .rf_r_en2(rf_r_en2),
    .rf_reg1(rf_reg1), .rf_reg2(rf_reg2), .rf_r_data1(rf_r_data1),
    .rf_r_data2(rf_r_data2), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_rd(out_rd), .out_a(out_a), .out_b(out_b), .out_imm(out_imm),
    .out_pc(out_pc), .out_wr(out_wr), .halted(halted), .stall_cycles(stall_cycles)
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] a, b, imm, pc;
    logic        wr;
  } exp_t;

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    int          due;
  } wb_t;

  exp_t        sbq[$];
  wb_t         wbq[$];
  logic [15:0] rf[8];
  logic [15:0] arch[8];
  int          inflight[8];
  int          total = 0, bad = 0, cyc = 0;
  int          ready_mode = 0;
  int          wb_delay = 0;
  logic [16:0] wb_force = '0;
  int          last_wait;
  logic        last_en1, last_en2;

  assign rf_r_data1 = rf[rf_reg1[2:0]];
  assign rf_r_data2 = rf[rf_reg2[2:0]];

  task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [15:0] reg_val(input logic [2:0] r);
    return (r == 3'd0) ? 16'h0000 : arch[r];
  endfunction

  // Expected decode result from the instruction-set rules and the
  // program-order register values.
  function automatic exp_t predict(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    int   op;
    int   i6;
    op    = int'(instr[15:12]);
    i6    = int'(instr[5:0]);
    e.op  = instr[15:12];
    e.rd  = instr[11:9];
    e.pc  = pc;
    e.a   = 16'h0;
    e.b   = 16'h0;
    e.imm = 16'h0;
    if (op <= 7) begin
      e.a = reg_val(instr[8:6]);
      e.b = reg_val(instr[5:3]);
    end else if (op <= 14) begin
      e.a   = reg_val(instr[8:6]);
      e.imm = 16'((i6 >= 32) ? i6 - 64 : i6);
    end
    e.wr = (op != 7) && (op != 14) && (op != 15) && (instr[11:9] != 3'd0);
    return e;
  endfunction

  // Execute side: consumes ops, checks them, and retires their writes later.
  initial begin : monitor
    exp_t        e;
    logic [15:0] v;
    int          d;
    logic [71:0] got, snap;
    bit          snap_ok;
    wb_valid  = 1'b0;
    wb_rd     = '0;
    wb_data   = '0;
    out_ready = 1'b1;
    snap_ok   = 1'b0;
    snap      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (wb_valid) rf[wb_rd] = wb_data;
      wb_valid = 1'b0;
      if (wbq.size() > 0 && wbq[0].due <= cyc) begin
        wb_valid = 1'b1;
        wb_rd    = wbq[0].rd;
        wb_data  = wbq[0].val;
        inflight[wbq[0].rd]--;
        void'(wbq.pop_front());
      end
      case (ready_mode)
        1:       out_ready = 1'b1;
        2:       out_ready = 1'b0;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      got = {out_opcode, out_rd, out_a, out_b, out_imm, out_pc, out_wr};
      if (reset) begin
        wb_valid = 1'b0;
        sbq.delete();
        wbq.delete();
        foreach (inflight[i]) inflight[i] = 0;
        foreach (arch[i]) arch[i] = rf[i];
        snap_ok = 1'b0;
      end else begin
        if (snap_ok) chk("hold_stable", got, snap);
        snap_ok = out_valid && !out_ready;
        snap    = got;
        if (out_valid && out_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out got=%0h want=none", got);
          end else begin
            e = sbq.pop_front();
            chk("out_fields", got, 72'(e));
            if (e.wr) begin
              v        = wb_force[16] ? wb_force[15:0] : 16'($urandom);
              wb_force = '0;
              arch[e.rd] = v;
              d = (wb_delay > 0) ? wb_delay : $urandom_range(1, 5);
              wbq.push_back('{e.rd, v, cyc + d});
            end
          end
        end
      end
    end
  end

  task automatic issue(input logic [15:0] instr, input logic [15:0] pc);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    for (int n = 0; n <= 200; n++) begin
      #1;
      if (in_ready) begin
        e = predict(instr, pc);
        sbq.push_back(e);
        if (e.wr) inflight[e.rd]++;
        last_wait = n;
        last_en1  = rf_r_en1;
        last_en2  = rf_r_en2;
        return;
      end
      @(negedge clk);
    end
    total++;
    bad++;
    $display("FAIL issue_timeout got=no_accept want=accept instr=%h", instr);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_instr = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || wbq.size() != 0) && n < 300) begin
      @(negedge clk);
      in_valid = 1'b0;
      n++;
    end
    if (sbq.size() != 0 || wbq.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout got=%0d want=0", sbq.size() + wbq.size());
    end
  endtask

  initial begin : driver
    logic [15:0] stall_before;
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [15:0] instr;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_instr = '0;
    in_pc    = '0;
    foreach (rf[i]) rf[i] = 16'($urandom);
    rf[0] = 16'hBEEF;
    rf[1] = 16'h0304;
    rf[2] = 16'h0102;
    foreach (arch[i]) arch[i] = rf[i];
    foreach (inflight[i]) inflight[i] = 0;

    // Reset state.
    do_reset();
    #1;
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_halted", 72'(halted), 72'(0));
    chk("rst_stall", 72'(stall_cycles), 72'(0));
    chk("rst_in_ready", 72'(in_ready), 72'(1));
    chk("rst_out_data", {out_opcode, out_rd, out_a, out_b, out_imm, out_pc, out_wr}, 72'(0));

    // First R-type op, then a RAW reader with writeback three cycles later.
    ready_mode = 1;
    wb_delay   = 3;
    wb_force   = 17'h10506;
    issue(16'h0288, 16'h0100);
    chk("rtype_en1", 72'(last_en1), 72'(1));
    chk("rtype_en2", 72'(last_en2), 72'(1));
    issue(16'h0440, 16'h0102);
`ifdef BYPASS_EN
    chk("raw_stall", 72'(stall_cycles), 72'(3));
`else
    chk("raw_stall", 72'(stall_cycles), 72'(4));
`endif

    // I-type with negative immediate.
    issue(16'h86BF, 16'h0104);
    chk("itype_en1", 72'(last_en1), 72'(1));
    chk("itype_en2", 72'(last_en2), 72'(0));

    // r0 sources read zero and never stall; rd = 0 does not write.
    stall_before = stall_cycles;
    issue(16'h1000, 16'h0106);
    chk("r0_nowait", 72'(last_wait), 72'(0));
    chk("r0_nostall", 72'(stall_cycles), 72'(stall_before));

    // Back-pressure: output held four cycles, then the waiting op goes in.
    idle(10);
    #2;
    ready_mode = 2;
    issue(16'h2800, 16'h0200);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = 16'h3A00;
      in_pc    = 16'h0202;
      #1;
      chk("held_in_ready", 72'(in_ready), 72'(0));
    end
    ready_mode = 1;
    issue(16'h3A00, 16'h0202);
    chk("resume_wait", 72'(last_wait), 72'(0));

    // Random instruction stream with random back-pressure and writeback delay.
    idle(2);
    #2;
    ready_mode = 0;
    wb_delay   = 0;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      op = 4'($urandom_range(0, 14));
      rd = 3'($urandom_range(0, 7));
      if (inflight[rd] != 0) rd = 3'd0;
      instr = {op, rd, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63))};
      issue(instr, 16'(16'h1000 + 2 * k));
    end
    #2;
    ready_mode = 1;
    drain();

    // Halt with a write still outstanding, then reset clears everything.
    #2;
    wb_delay = 50;
    issue(16'h0A00, 16'h0300);
    issue(16'hF000, 16'h0302);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = 16'h1000;
      in_pc    = 16'h0304;
      #1;
      chk("halted_flag", 72'(halted), 72'(1));
      chk("halted_in_ready", 72'(in_ready), 72'(0));
    end
    do_reset();
    #1;
    chk("post_rst_halted", 72'(halted), 72'(0));
    chk("post_rst_out_valid", 72'(out_valid), 72'(0));
    wb_delay = 0;
    issue(16'h1140, 16'h0400);
    chk("post_rst_pending", 72'(last_wait), 72'(0));
    idle(2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
